// File: rtl/miner_pkg.sv
// Shared constants and helpers for the SHA-256 miner datapath.
// Latency: n/a (package). Backpressure: n/a.
// Contents: SHA word width, message-schedule window depth, 32-bit byte swap.
package miner_pkg;

  localparam int SHA_WORD_W    = 32;
  localparam int SHA_WIN_DEPTH = 16;

  // Reverse byte order of a 32-bit word (little-endian header -> SHA big-endian).
  function automatic logic [SHA_WORD_W-1:0] bswap_word(input logic [SHA_WORD_W-1:0] w);
    logic [SHA_WORD_W-1:0] r;
    r = '0;
    for (int b = 0; b < SHA_WORD_W/8; b++) begin
      r[b*8 +: 8] = w[(SHA_WORD_W/8-1-b)*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/word_reg.sv
// Single WIDTH-bit register with enable and synchronous clear.
// Latency: 1 cycle from d to q. Backpressure: none; en=0 holds the value.
// Ports: clk, clr (sync, active-high, wins over en), en, d -> q.
module word_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/word_window_reg.sv
// Multi-word SHA-256 message window: parallel load, shift-in with oldest discard,
// indexed tap, fill count and drop flags. Latency: writes visible 1 cycle after
// the edge, rd_q/full combinational. Backpressure: none; en=0 freezes all state.
// Ports: clk, clr, en, load, load_data, shift, d, rd_idx -> rd_q, q_flat, count,
// full, drop, drop_sticky. Word 0 is the oldest; word i at bits [i*WIDTH +: WIDTH].
// Optional macro WORD_WINDOW_BYTESWAP_EN adds input swap: byte-reverses d and
// every load_data word before storing (WIDTH must be a multiple of 8).
module word_window_reg
  import miner_pkg::*;
#(
  parameter  int WIDTH = SHA_WORD_W,
  parameter  int DEPTH = SHA_WIN_DEPTH,
  localparam int IDX_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH+1)
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   en,
  input  logic                   load,
  input  logic [WIDTH*DEPTH-1:0] load_data,
  input  logic                   shift,
  input  logic [WIDTH-1:0]       d,
`ifdef WORD_WINDOW_BYTESWAP_EN
  input  logic                   swap,
`endif
  input  logic [IDX_W-1:0]       rd_idx,
  output logic [WIDTH-1:0]       rd_q,
  output logic [WIDTH*DEPTH-1:0] q_flat,
  output logic [CNT_W-1:0]       count,
  output logic                   full,
  output logic                   drop,
  output logic                   drop_sticky
);

  if (DEPTH < 2) begin : g_depth_chk
    $error("word_window_reg: DEPTH must be 2 or more");
  end

`ifdef WORD_WINDOW_BYTESWAP_EN
  if (WIDTH % 8 != 0) begin : g_width_chk
    $error("word_window_reg: WIDTH must be a multiple of 8 for byte swap");
  end

  function automatic logic [WIDTH-1:0] fmt_word(input logic [WIDTH-1:0] w, input logic s);
    logic [WIDTH-1:0] r;
    r = w;
    if (s) begin
      if (WIDTH == SHA_WORD_W) begin
        r = WIDTH'(bswap_word(SHA_WORD_W'(w)));
      end else begin
        for (int b = 0; b < WIDTH/8; b++) begin
          r[b*8 +: 8] = w[(WIDTH/8-1-b)*8 +: 8];
        end
      end
    end
    return r;
  endfunction
`endif

  logic [WIDTH-1:0] words     [DEPTH];
  logic [WIDTH-1:0] word_next [DEPTH];
  logic [WIDTH-1:0] d_in;
  logic             word_en;

`ifdef WORD_WINDOW_BYTESWAP_EN
  assign d_in = fmt_word(d, swap);
`else
  assign d_in = d;
`endif

  // Load and shift both rewrite every word, so one shared enable suffices.
  assign word_en = en & (load | shift);

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    logic [WIDTH-1:0] ld_w;
    logic [WIDTH-1:0] sh_w;

`ifdef WORD_WINDOW_BYTESWAP_EN
    assign ld_w = fmt_word(load_data[i*WIDTH +: WIDTH], swap);
`else
    assign ld_w = load_data[i*WIDTH +: WIDTH];
`endif

    if (i == DEPTH-1) begin : g_tail
      assign sh_w = d_in;
    end else begin : g_body
      assign sh_w = words[i+1];
    end

    assign word_next[i] = load ? ld_w : sh_w;

    word_reg #(.WIDTH(WIDTH)) u_word (
      .clk (clk),
      .clr (clr),
      .en  (word_en),
      .d   (word_next[i]),
      .q   (words[i])
    );

    assign q_flat[i*WIDTH +: WIDTH] = words[i];
  end

  // Tap table padded to a power of two so out-of-range indices read zero.
  logic [WIDTH-1:0] tap [2**IDX_W];

  always_comb begin
    for (int k = 0; k < 2**IDX_W; k++) begin
      tap[k] = '0;
    end
    for (int k = 0; k < DEPTH; k++) begin
      tap[k] = words[k];
    end
  end

  assign rd_q = tap[rd_idx];
  assign full = (count == CNT_W'(DEPTH));

  always_ff @(posedge clk) begin
    if (clr) begin
      count       <= '0;
      drop        <= 1'b0;
      drop_sticky <= 1'b0;
    end else if (!en) begin
      drop <= 1'b0;
    end else if (load) begin
      count <= CNT_W'(DEPTH);
      drop  <= 1'b0;
    end else if (shift) begin
      if (full) begin
        // Oldest valid word falls off the end.
        drop        <= 1'b1;
        drop_sticky <= 1'b1;
      end else begin
        count <= count + 1'b1;
        drop  <= 1'b0;
      end
    end else begin
      drop <= 1'b0;
    end
  end

endmodule

// File: doc/word_window_reg.md
Name: word_window_reg

Overview:
- Parametrised multi-word register window for SHA-256 message words, e.g. the W[t-16..t-1] schedule window and 16-word block buffer.
- Generalises the single enabled register to DEPTH words of WIDTH bits.
- Supports parallel load, shift-in with oldest-word discard, indexed tap read, fill tracking and a sticky drop flag.
- Sits between the block/nonce loader and the SHA-256 round datapath.

Parameters:
- WIDTH, 32, bits per word.
- DEPTH, 16, number of words in the window; must be 2 or more.
- IDX_W, $clog2(DEPTH), derived localparam; width of rd_idx.
- CNT_W, $clog2(DEPTH+1), derived localparam; width of count.

Ports:
- clk  in  1  rising-edge clock.
- clr  in  1  synchronous active-high reset.
- en  in  1  global enable; when low, all state holds.
- load  in  1  parallel-load strobe.
- load_data  in  WIDTH*DEPTH  parallel image; word i is at bits [i*WIDTH +: WIDTH].
- shift  in  1  shift-in strobe.
- d  in  WIDTH  word shifted in.
- rd_idx  in  IDX_W  tap select.
- rd_q  out  WIDTH  selected word.
- q_flat  out  WIDTH*DEPTH  all words, same packing as load_data.
- count  out  CNT_W  number of valid words, 0..DEPTH.
- full  out  1  high when count == DEPTH.
- drop  out  1  one-cycle pulse: a valid oldest word was discarded.
- drop_sticky  out  1  latched drop; cleared only by clr.

Behaviour:
- All state updates on the rising clk edge.
- Priority per cycle: clr > !en > load > shift > hold.
- clr: all words 0, count 0, drop 0, drop_sticky 0. This applies mid-operation too; any concurrent load or shift is ignored.
- en=0: words, count and drop_sticky hold; drop is 0.
- Load (en=1, load=1):
  - word[i] <= load_data word i.
  - count <= DEPTH.
  - drop 0.
  - Any concurrent shift is ignored.
- Shift (en=1, load=0, shift=1):
  - word[i] <= word[i+1] for i < DEPTH-1.
  - word[DEPTH-1] <= d.
  - word[0] content is discarded; word 0 is the oldest.
  - If count < DEPTH: count increments.
  - If count == DEPTH: count stays DEPTH, drop = 1 that cycle, drop_sticky <= 1.
- Hold (en=1, neither load nor shift): no change; drop 0.
- drop is registered: it is high in the cycle after the discarding edge.
- rd_q:
  - Combinational from rd_idx and the current words; 0 cycles from rd_idx.
  - A write is visible 1 cycle after the load/shift edge.
  - rd_idx >= DEPTH (non-power-of-2 DEPTH) returns 0.
- full is combinational from count.
- Partially filled window: valid words are word[DEPTH-count .. DEPTH-1]. Unfilled words read as their current contents (0 after clr); no masking.
- No X propagation: every register has a defined clr value.

Optional Feature:
- Macro: WORD_WINDOW_BYTESWAP_EN.
- Defined:
  - Adds input port swap (1 bit).
  - When swap=1, d and every load_data word are byte-reversed before storing (byte 0 <-> byte WIDTH/8-1).
  - Used to convert little-endian block-header words to SHA big-endian order.
  - WIDTH must be a multiple of 8; violating this is a compile-time error.
- Undefined: no swap port; data is stored unmodified.

Decomposition:
- Package miner_pkg:
  - SHA_WORD_W = 32.
  - SHA_WIN_DEPTH = 16.
  - Byte-swap function bswap_word, used by this block and the header loader.
- One natural sub-module: word_reg.
  - Parametrised WIDTH register with en and synchronous clr.
  - Instantiated DEPTH times in a generate loop.
  - Its count/flag logic stays in the top level.

Test Plan (WIDTH=32, DEPTH=16 unless stated):
- Reset then idle:
  - Stimulus: clr=1 for 2 cycles, then hold.
  - Response: q_flat=0, count=0, full=0, drop=0, drop_sticky=0, rd_q=0 for every rd_idx.
- Fill by shifting:
  - Stimulus: shift 16 words d=0x0000_0001..0x0000_0010.
  - Response: count steps 1..16; full=1 after the 16th edge; word[0]=0x1; word[15]=0x10; rd_idx=5 gives 0x6.
- Overflow:
  - Stimulus: with the window full, shift d=0xDEADBEEF.
  - Response: word[0]=0x2, word[15]=0xDEADBEEF, count=16, drop pulses 1 cycle, drop_sticky=1 until clr.
- Load vs shift collision:
  - Stimulus: load=1 and shift=1 together, load_data word i=0xA000_0000+i.
  - Response: word[i]=0xA000_0000+i, d ignored, count=16, drop=0.
- Enable low and clr mid-operation:
  - Stimulus: en=0 with shift=1 for 3 cycles.
  - Response: state unchanged.
  - Stimulus: then clr=1 together with load=1.
  - Response: all zero, count=0.
- Byteswap (macro defined):
  - Stimulus: swap=1, shift d=0x11223344.
  - Response: word[15]=0x44332211.
  - Stimulus: swap=0.
  - Response: stored unmodified.
